// File: rtl/key_pulse_gen_pkg.sv
// key_pulse_gen_pkg
//   Shared constants for the push-button front end: key index assignment,
//   default key count and default debounce length.
//   Ports: none (package).

package key_pulse_gen_pkg;

    localparam int KEY_UP     = 0;
    localparam int KEY_DOWN   = 1;
    localparam int KEY_LEFT   = 2;
    localparam int KEY_RIGHT  = 3;
    localparam int KEY_SWITCH = 4;

    localparam int N_KEYS_DEF          = 5;
    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef logic [N_KEYS_DEF-1:0] key_vec_t;

endpackage

// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if
//   Bundles the per-key vectors exchanged between the button front end and
//   its environment.
//   Signals: key_raw (raw levels in), key_level (debounced levels),
//   key_pulse (one-hot press event), key_pending (accepted, not yet emitted).
//   Modports: master = environment side, slave = key_pulse_gen side.

interface key_pulse_gen_if
    import key_pulse_gen_pkg::*;
#(
    parameter int N_KEYS = N_KEYS_DEF
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_pulse;
    logic [N_KEYS-1:0] key_pending;

    modport master (
        output key_raw,
        input  key_level,
        input  key_pulse,
        input  key_pending
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_pulse,
        output key_pending
    );
endinterface

// File: rtl/key_pulse_gen_debounce.sv
// key_debounce
//   Single-key 2-FF synchroniser followed by a stability counter.
//   Ports:
//     clk, reset   system clock, synchronous active-high reset
//     key_raw      asynchronous raw button level (1 = pressed)
//     level        debounced level
//     rise         combinational strobe, high in the cycle whose edge takes
//                  level from 0 to 1
//   DEBOUNCE_CYCLES must be >= 2.

module key_debounce
    import key_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level,
    output logic rise
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          toggle;

    // The mismatching cycle that would bring the count to DEBOUNCE_CYCLES
    // flips the level instead.
    assign toggle = (sync2 != level) && (cnt == CNT_LAST);
    assign rise   = toggle && !level;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (toggle) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen
//   Push-button conditioner: per-key synchronise + debounce, press capture
//   into a pending register, and a lowest-index-first arbiter that emits at
//   most one single-cycle key pulse per clock.
//   Ports:
//     clk, reset  system clock, synchronous active-high reset
//     bus         key_pulse_gen_if.slave: key_raw in; key_level, key_pulse,
//                 key_pending out
//   Build option: define KEY_AUTOREPEAT_EN to add per-key hold counters that
//   re-raise pending after REPEAT_DELAY cycles held and every REPEAT_PERIOD
//   cycles after that (KEY_SWITCH never repeats).

module key_pulse_gen
    import key_pulse_gen_pkg::*;
#(
    parameter int N_KEYS          = N_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic            clk,
    input  logic            reset,
    key_pulse_gen_if.slave  bus
);

    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] rise;
    logic [N_KEYS-1:0] rpt_set;
    logic [N_KEYS-1:0] pending;
    logic [N_KEYS-1:0] pending_nxt;
    logic [N_KEYS-1:0] grant;
    logic [N_KEYS-1:0] pulse;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .key_raw (bus.key_raw[i]),
            .level   (level[i]),
            .rise    (rise[i])
        );
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_rpt
        if (i == KEY_SWITCH) begin : g_none
            assign rpt_set[i] = 1'b0;
        end else begin : g_hold
            logic [RW-1:0] hold_cnt;

            // Down-counter loaded on the press edge; reaching zero while
            // still held raises pending and reloads with the repeat period.
            always_ff @(posedge clk) begin
                if (reset) begin
                    hold_cnt <= '0;
                end else if (rise[i]) begin
                    hold_cnt <= RW'(REPEAT_DELAY - 1);
                end else if (!level[i]) begin
                    hold_cnt <= '0;
                end else if (hold_cnt == '0) begin
                    hold_cnt <= RW'(REPEAT_PERIOD - 1);
                end else begin
                    hold_cnt <= hold_cnt - RW'(1);
                end
            end

            assign rpt_set[i] = level[i] && (hold_cnt == '0);
        end
    end
`else
    assign rpt_set = '0;
`endif

    // Isolate the lowest set pending bit (two's-complement trick).
    assign grant = pending & (~pending + N_KEYS'(1));

    // A press landing on the bit being granted re-arms it, so it is not lost.
    assign pending_nxt = (pending & ~grant) | rise | rpt_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            pulse   <= '0;
        end else begin
            pending <= pending_nxt;
            pulse   <= grant;
        end
    end

    assign bus.key_level   = level;
    assign bus.key_pulse   = pulse;
    assign bus.key_pending = pending;

endmodule

// File: tb/tb_key_pulse_gen.sv
module tb_key_pulse_gen;
    import key_pulse_gen_pkg::*;

    localparam int N    = 5;
    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;

    key_pulse_gen_if #(.N_KEYS(N)) bus ();

    key_pulse_gen #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulse_cnt [N] = '{default: 0};

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: level flips when the synced input (raw two samples
    // back, zero across a reset) has disagreed with it on each of the last
    // D edges since the previous flip/reset; rises feed a pending set that
    // is drained lowest index first, one per edge.
    // ------------------------------------------------------------------
    logic [N-1:0] raw_h [MAXC];
    bit           rst_h [MAXC];
    logic [N-1:0] syn_h [MAXC];
    int           n_edge = -1;
    int           last_evt [N] = '{default: 0};
    int           hold_start [N] = '{default: 0};
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_pend  = '0;
    logic [N-1:0] m_pulse = '0;
    bit           model_on = 1'b0;

    always @(posedge clk) begin
        logic [N-1:0] s;
        logic [N-1:0] np;
        logic [N-1:0] sel;
        bit           tog;
        int           age;
        n_edge++;
        raw_h[n_edge] = bus.key_raw;
        rst_h[n_edge] = reset;
        if (n_edge < 2) s = '0;
        else if (rst_h[n_edge-1] || rst_h[n_edge-2]) s = '0;
        else s = raw_h[n_edge-2];
        syn_h[n_edge] = s;
        if (reset) begin
            m_level = '0;
            m_pend  = '0;
            m_pulse = '0;
            for (int k = 0; k < N; k++) last_evt[k] = n_edge;
        end else begin
            sel = '0;
            for (int k = N - 1; k >= 0; k--) begin
                if (m_pend[k]) begin
                    sel = '0;
                    sel[k] = 1'b1;
                end
            end
            np = m_pend & ~sel;
            for (int k = 0; k < N; k++) begin
`ifdef KEY_AUTOREPEAT_EN
                if (m_level[k] && k != KEY_SWITCH) begin
                    age = n_edge - hold_start[k];
                    if (age == RD || (age > RD && (age - RD) % RP == 0)) np[k] = 1'b1;
                end
`endif
                age = 0;
                tog = (n_edge - D + 1 > last_evt[k]);
                if (tog) begin
                    for (int j = 0; j < D; j++)
                        if (syn_h[n_edge-j][k] == m_level[k]) tog = 1'b0;
                end
                if (tog) begin
                    last_evt[k] = n_edge;
                    if (!m_level[k]) begin
                        np[k] = 1'b1;
                        hold_start[k] = n_edge;
                    end
                    m_level[k] = ~m_level[k];
                end
            end
            m_pend  = np;
            m_pulse = sel;
        end
        model_on = 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_level",   bus.key_level,   m_level);
            chk("model_pulse",   bus.key_pulse,   m_pulse);
            chk("model_pending", bus.key_pending, m_pend);
            for (int k = 0; k < N; k++)
                if (bus.key_pulse[k] === 1'b1) pulse_cnt[k]++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.key_raw = '0;
        reset = 1'b1;
        cyc(3);
        chk("rst_level",   bus.key_level,   5'b00000);
        chk("rst_pulse",   bus.key_pulse,   5'b00000);
        chk("rst_pending", bus.key_pending, 5'b00000);
        reset = 1'b0;
        cyc(2);

        // clean press on key 0
        bus.key_raw = 5'b00001;
        cyc(5);
        chk("t1_level_early", bus.key_level, 5'b00000);
        cyc(1);
        chk("t1_level_rise",  bus.key_level,   5'b00001);
        chk("t1_pend_set",    bus.key_pending, 5'b00001);
        chk("t1_pulse_wait",  bus.key_pulse,   5'b00000);
        cyc(1);
        chk("t1_pulse",       bus.key_pulse,   5'b00001);
        chk("t1_pend_clr",    bus.key_pending, 5'b00000);
        cyc(1);
        chk("t1_pulse_end",   bus.key_pulse,   5'b00000);
        cyc(10);
        bus.key_raw = '0;
        cyc(10);
        chk_int("t1_pulse_cnt", pulse_cnt[0], 1);

        // bounce on key 2
        bus.key_raw = 5'b00100; cyc(2);
        bus.key_raw = 5'b00000; cyc(2);
        bus.key_raw = 5'b00100; cyc(2);
        bus.key_raw = 5'b00000; cyc(10);
        chk("t2_level", bus.key_level, 5'b00000);
        chk_int("t2_pulse_cnt", pulse_cnt[2], 0);

        // simultaneous press on keys 1 and 3
        bus.key_raw = 5'b01010;
        cyc(6);
        chk("t3_pend_both", bus.key_pending, 5'b01010);
        cyc(1);
        chk("t3_pulse1",    bus.key_pulse,   5'b00010);
        chk("t3_pend_3",    bus.key_pending, 5'b01000);
        cyc(1);
        chk("t3_pulse3",    bus.key_pulse,   5'b01000);
        chk("t3_pend_none", bus.key_pending, 5'b00000);
        cyc(1);
        chk("t3_pulse_end", bus.key_pulse,   5'b00000);
        bus.key_raw = '0;
        cyc(10);

        // re-press on key 4: full release, then a too-short release
        bus.key_raw = 5'b10000; cyc(10);
        bus.key_raw = 5'b00000; cyc(8);
        bus.key_raw = 5'b10000; cyc(10);
        chk_int("t4_two_pulses", pulse_cnt[4], 2);
        bus.key_raw = 5'b00000; cyc(3);
        bus.key_raw = 5'b10000; cyc(12);
        chk_int("t4_short_release", pulse_cnt[4], 2);
        bus.key_raw = '0;
        cyc(10);

        // reset while keys 1 and 2 are pending
        bus.key_raw = 5'b00110;
        cyc(6);
        chk("t5_pend_pre", bus.key_pending, 5'b00110);
        reset = 1'b1;
        bus.key_raw = '0;
        cyc(1);
        chk("t5_level", bus.key_level,   5'b00000);
        chk("t5_pulse", bus.key_pulse,   5'b00000);
        chk("t5_pend",  bus.key_pending, 5'b00000);
        cyc(1);
        reset = 1'b0;
        cyc(15);
        chk_int("t5_key1_cnt", pulse_cnt[1], 1);
        chk_int("t5_key2_cnt", pulse_cnt[2], 0);
        bus.key_raw = 5'b01000;
        cyc(10);
        chk_int("t5_key3_after", pulse_cnt[3], 2);
        bus.key_raw = '0;
        cyc(10);

`ifdef KEY_AUTOREPEAT_EN
        begin
            int base4;
            bus.key_raw = 5'b00001;
            cyc(6);
            chk("ar_level_rise", bus.key_level, 5'b00001);
            for (int c = 1; c <= 40; c++) begin
                cyc(1);
                if (c == 1 || c == 21 || c == 29 || c == 37)
                    chk("ar_pulse_on", bus.key_pulse, 5'b00001);
                else
                    chk("ar_pulse_off", bus.key_pulse, 5'b00000);
            end
            bus.key_raw = '0;
            cyc(10);
            base4 = pulse_cnt[4];
            bus.key_raw = 5'b10000;
            cyc(46);
            bus.key_raw = '0;
            cyc(10);
            chk_int("ar_switch_single", pulse_cnt[4], base4 + 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/key_pulse_gen.md
Name: key_pulse_gen

Overview:
- Upstream input conditioner for the game core.
- Takes raw asynchronous push-button levels (up, down, left, right, switch) and synchronises and debounces each one.
- Converts each debounced press into exactly one single-cycle pulse.
- Arbitrates so at most one key pulse is issued per clock.
- key_pulse[KEY_SWITCH] drives the mode-switch controller's key input; the direction pulses drive the move engine.

Parameters:
- N_KEYS, 5, number of buttons handled; index assignment fixed by the shared package.
- DEBOUNCE_CYCLES, 500000, consecutive stable synced cycles needed to accept a level change (10 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, hold time before the first auto-repeat pulse (used only with KEY_AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, interval between subsequent auto-repeat pulses (used only with KEY_AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- key_raw  input  N_KEYS  raw button levels, asynchronous, 1 = pressed.
- key_level  output  N_KEYS  debounced level per key.
- key_pulse  output  N_KEYS  one-hot or zero; single-cycle press event.
- key_pending  output  N_KEYS  presses accepted but not yet emitted.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - sync flops, debounced levels, counters, pending and key_pulse all clear to 0.
  - A key already held at reset release produces a pulse only after full debounce, since key_level starts at 0.
- Synchroniser: 2-FF per key; synced value is key_raw delayed 2 cycles.
- Debounce, per key:
  - counter width = $clog2(DEBOUNCE_CYCLES+1).
  - If synced == key_level, counter clears to 0.
  - Otherwise counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, key_level toggles and the counter clears.
  - Any bounce back to key_level before then clears the counter (glitch rejected).
  - Latency: a raw edge held stable changes key_level exactly DEBOUNCE_CYCLES+2 cycles later.
- Press detect: a 0->1 transition of key_level sets pending[i] in the same cycle the level changes. 1->0 transitions do nothing.
- Arbiter:
  - Each cycle, the lowest-index set pending bit is selected.
  - key_pulse (registered) asserts that bit for exactly one cycle on the next edge, and that pending bit clears.
  - Other pending bits are held, so no press is ever lost.
- Latency: key_level rise -> key_pulse high one cycle later when no lower-index key is pending.
- Simultaneous events:
  - A new rise on a key whose pending bit is already set merges; only one pulse results.
  - A rise in the same cycle that the same bit is being granted re-sets pending, giving a second pulse later.
- Release and re-press: a new pulse requires a full release debounce followed by a press debounce.
- Reset mid-operation: all pending presses are discarded and no pulse is issued in the cycle after reset.

Optional Feature:
- Macro KEY_AUTOREPEAT_EN.
- When defined:
  - Each key has a hold counter that starts on the key_level rise.
  - The first repeat sets pending after REPEAT_DELAY cycles of continuous key_level=1; further repeats follow every REPEAT_PERIOD cycles.
  - The counter clears on key_level fall or reset.
  - The KEY_SWITCH index is excluded from repeat.
- When undefined: no hold counters, one pulse per press only.

Decomposition:
- Shared package holds:
  - key index constants KEY_UP=0, KEY_DOWN=1, KEY_LEFT=2, KEY_RIGHT=3, KEY_SWITCH=4.
  - N_KEYS default.
  - default DEBOUNCE_CYCLES.
- One sub-module, key_debounce: a single-key synchroniser plus counter, outputting level and a rise strobe. It is instantiated N_KEYS times via generate.
- The arbiter, pending register and optional auto-repeat live in key_pulse_gen.

Test Plan (DEBOUNCE_CYCLES=4 in bench):
- Clean press: key_raw[0] 0->1 held -> key_level[0] rises 6 cycles later; key_pulse=5'b00001 for exactly 1 cycle on the next cycle; no further pulse while held.
- Bounce rejection: key_raw[2] toggles 1,0,1,0 with a 2-cycle period, then stays 0 -> key_level[2] stays 0 and no pulse.
- Simultaneous press: key_raw[1] and key_raw[3] rise in the same cycle -> key_pulse=00010, then 01000 on the following cycle; key_pending shows 01010 then 01000 then 0.
- Re-press: press, release for 6+ cycles, press again on key 4 -> two separate 10000 pulses; release shorter than 4 stable cycles -> one pulse only.
- Reset mid-operation: assert reset while key_pending=00110 -> all outputs 0 the cycle after; no pulses after release until a new debounced press.
- With KEY_AUTOREPEAT_EN (REPEAT_DELAY=20, REPEAT_PERIOD=8): hold key 0 for 40 cycles after key_level rise -> pulses at +1, +21, +29, +37. Holding key 4 -> a single pulse.
